sipo_deser: RTL and testbench

- Serial-to-parallel deserializer that consumes the single-bit output of the upstream one-bit registered stage (one bit per `clk` edge, qualified by `di_valid`).
- Uses a start-of-frame marker to align bits into WIDTH-bit words.
- Presents each word on a valid/ready output port to downstream logic.
- Holds one output word; flags overrun when a new word completes before the previous word is accepted.

---
 rtl/sipo_deser_pkg.sv | 14 +
 rtl/sipo_shift_core.sv | 52 +++++
 rtl/sipo_deser.sv | 92 +++++++++
 tb/tb_sipo_deser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Imported by the top level and the shift core.
package sipo_deser_pkg;

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for one frame word.
// o_word includes the bit being accepted this cycle.
module sipo_shift_core
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_bit,
  input  logic                    i_en,
  input  logic                    i_restart,
  output logic [WIDTH-1:0]        o_word,
  output logic [cnt_w(WIDTH)-1:0] o_cnt,
  output logic                    o_done
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_pos;
  logic [CW-1:0]    w_idx;

  // sof restarts at position 0 and drops the partial word
  always_comb begin
    w_pos = i_restart ? '0 : r_cnt;
    w_idx = MSB_FIRST ? CW'(WIDTH-1) - w_pos
                      : w_pos;
    w_word = i_restart ? '0 : r_word;
    w_word[w_idx] = i_bit;
  end

  assign o_done = i_en
               && (w_pos == CW'(WIDTH-1));
  assign o_word = w_word;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_word <= o_done ? '0 : w_word;
      r_cnt  <= o_done ? '0
                       : w_pos + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: framing FSM, output word
// register with valid/ready handshake and overrun flag.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    di,
  input  logic                    di_valid,
  input  logic                    sof,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    overrun,
  input  logic                    clr_overrun,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt
);

  state_t r_state;
  state_t w_state_nxt;

  logic             w_en;
  logic             w_done;
  logic             w_drop;
  logic             w_accept;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  always_comb begin
    w_state_nxt = r_state;
    w_en        = 1'b0;
    unique case (r_state)
      HUNT: begin
        w_en = di_valid && sof;
        if (w_en) w_state_nxt = COLLECT;
      end
      COLLECT: w_en = di_valid;
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bit     (di),
    .i_en      (w_en),
    .i_restart (sof),
    .o_word    (w_word),
    .o_cnt     (bit_cnt),
    .o_done    (w_done)
  );

  assign w_accept = r_dout_valid && dout_ready;
  assign w_drop   = w_done && r_dout_valid
                 && !dout_ready;

  // a word completing alongside an accept replaces it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_done && !w_drop) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (w_accept) begin
        r_dout_valid <= 1'b0;
      end
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one LSB-first and
// one MSB-first instance share the same stimulus.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       di = 1'b0;
  logic       di_valid = 1'b0;
  logic       sof = 1'b0;
  logic       dout_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, ovr0, ovr1;
  logic [2:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .di(di),
    .di_valid(di_valid), .sof(sof),
    .dout(dout0), .dout_valid(dv0),
    .dout_ready(dout_ready), .overrun(ovr0),
    .clr_overrun(clr_overrun), .bit_cnt(cnt0)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .di(di),
    .di_valid(di_valid), .sof(sof),
    .dout(dout1), .dout_valid(dv1),
    .dout_ready(dout_ready), .overrun(ovr1),
    .clr_overrun(clr_overrun), .bit_cnt(cnt1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic b,
                      input logic v,
                      input logic s);
    di = b;
    di_valid = v;
    sof = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  // w[k] is the k-th bit on the wire
  task automatic send_word(input logic [7:0] w,
                           input logic s);
    for (int k = 0; k < 8; k++)
      step(w[k], 1'b1, s && (k == 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] w;

    // reset state
    #3;
    chk("rst_dout", dout0, 8'h00);
    chk("rst_valid", dv0, 1'b0);
    chk("rst_ovr", ovr0, 1'b0);
    chk("rst_cnt", cnt0, 3'd0);
    rst_n = 1'b1;

    // 1: basic framing
    dout_ready = 1'b1;
    w = 8'h4D;
    for (int k = 0; k < 7; k++)
      step(w[k], 1'b1, k == 0);
    chk("t1_early_valid", dv0, 1'b0);
    chk("t1_cnt7", cnt0, 3'd7);
    step(w[7], 1'b1, 1'b0);
    chk("t1_valid", dv0, 1'b1);
    chk("t1_dout", dout0, 8'h4D);
    chk("t1_msb_dout", dout1, 8'hB2);
    idle();
    chk("t1_one_cycle", dv0, 1'b0);
    chk("t1_hold", dout0, 8'h4D);

    // 2: hunt
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(k[0], 1'b1, 1'b0);
      chk("t2_hunt_cnt", cnt0, 3'd0);
      chk("t2_hunt_valid", dv0, 1'b0);
    end
    send_word(8'hA5, 1'b1);
    chk("t2_valid", dv0, 1'b1);
    chk("t2_dout", dout0, 8'hA5);
    idle();
    chk("t2_single", dv0, 1'b0);

    // 3: backpressure, overrun, set-wins
    dout_ready = 1'b0;
    send_word(8'h11, 1'b1);
    chk("t3_w1", dout0, 8'h11);
    chk("t3_w1_valid", dv0, 1'b1);
    chk("t3_no_ovr", ovr0, 1'b0);
    send_word(8'h22, 1'b0);
    chk("t3_hold", dout0, 8'h11);
    chk("t3_ovr", ovr0, 1'b1);
    w = 8'h33;
    for (int k = 0; k < 7; k++)
      step(w[k], 1'b1, 1'b0);
    clr_overrun = 1'b1;
    step(w[7], 1'b1, 1'b0);
    clr_overrun = 1'b0;
    chk("t3_set_wins", ovr0, 1'b1);
    chk("t3_hold2", dout0, 8'h11);
    dout_ready = 1'b1;
    idle();
    dout_ready = 1'b0;
    chk("t3_accept", dv0, 1'b0);
    chk("t3_keep", dout0, 8'h11);
    chk("t3_ovr_sticky", ovr0, 1'b1);
    clr_overrun = 1'b1;
    idle();
    clr_overrun = 1'b0;
    chk("t3_clr", ovr0, 1'b0);

    // 4: resync on a new sof
    dout_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_cnt3", cnt0, 3'd3);
    send_word(8'hF0, 1'b1);
    chk("t4_dout", dout0, 8'hF0);
    chk("t4_valid", dv0, 1'b1);
    chk("t4_ovr", ovr0, 1'b0);
    idle();
    chk("t4_single", dv0, 1'b0);

    // 5: MSB-first streaming
    w = 8'h4D;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        step(w[k], 1'b1, (f == 0) && (k == 0));
        if (k == 0 && f > 0)
          chk("t5_gap_valid", dv1, 1'b0);
        if (k == 7) begin
          chk("t5_valid", dv1, 1'b1);
          chk("t5_dout", dout1, 8'hB2);
        end
      end
    end
    chk("t5_ovr", ovr1, 1'b0);
    idle();

    // 6: reset mid-word
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_cnt4", cnt0, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_dout", dout0, 8'h00);
    chk("t6_valid", dv0, 1'b0);
    chk("t6_cnt", cnt0, 3'd0);
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t6_no_word", dv0, 1'b0);
    chk("t6_hunt_cnt", cnt0, 3'd0);
    chk("t6_msb_no_word", dv1, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
